// File: rtl/mac_sched_pkg.sv
// Shared widths and FSM state encoding for the mac_sched burst MAC scheduler.
// The ABORT state exists only when MAC_SCHED_WDOG_EN is defined.
package mac_sched_pkg;
  localparam int OP_W    = 4;
  localparam int ACC_W   = 11;
  localparam int LEN_MAX = 8;
  localparam int CNT_W   = $clog2(LEN_MAX + 1);

`ifdef MAC_SCHED_WDOG_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
endpackage

// File: rtl/mac_sched_acc.sv
// Signed 4x4 multiply-accumulate datapath; acc_nxt is the value acc takes on load/accum.
// Latency: acc updates on the accepting edge; no backpressure of its own.
module mac_sched_acc
  import mac_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             load,
  input  logic             accum,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_nxt
);
  logic signed [2*OP_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         acc;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(ACC_W - 2*OP_W){prod[2*OP_W-1]}}, prod};
  assign acc_nxt  = load ? prod_ext : acc + prod_ext;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (load || accum) begin
      acc <= acc_nxt;
    end
  end
endmodule

// File: rtl/mac_sched.sv
// Two-requester round-robin burst MAC: result 1 cycle after the LEN-th accept, held until out_ready.
// Optional stall watchdog (MAC_SCHED_WDOG_EN) aborts a stuck burst with a one-cycle err pulse.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int LEN      = 8,
  parameter int WDOG_CYC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  in_a0,
  input  logic [OP_W-1:0]  in_b0,
  input  logic             in_valid0,
  output logic             in_ready0,
  input  logic [OP_W-1:0]  in_a1,
  input  logic [OP_W-1:0]  in_b1,
  input  logic             in_valid1,
  output logic             in_ready1,
  output logic [ACC_W-1:0] mac_out,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);
  state_t           state;
  logic             grant;
  logic             rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept;
  logic             first_beat;
  logic             last_beat;
  logic             acc_clear;
  logic [ACC_W-1:0] acc_nxt;

  assign in_ready0  = (state == RUN) && !grant;
  assign in_ready1  = (state == RUN) && grant;
  assign accept     = grant ? (in_valid1 && in_ready1) : (in_valid0 && in_ready0);
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == CNT_W'(LEN - 1));

`ifdef MAC_SCHED_WDOG_EN
  localparam int SW = $clog2(WDOG_CYC + 1);
  logic [SW-1:0] stall_cnt;
  logic          stall_hit;

  assign stall_hit = (state == RUN) && !accept && (stall_cnt == SW'(WDOG_CYC - 1));
  assign acc_clear = stall_hit;
`else
  logic unused_wdog;

  assign unused_wdog = (WDOG_CYC == 0);
  assign acc_clear   = 1'b0;
  assign err         = 1'b0;
`endif

  mac_sched_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .a       (grant ? in_a1 : in_a0),
    .b       (grant ? in_b1 : in_b0),
    .load    (accept && first_beat),
    .accum   (accept && !first_beat),
    .clear   (acc_clear),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      rr_ptr    <= 1'b0;
      beat_cnt  <= '0;
      mac_out   <= '0;
      out_src   <= 1'b0;
      out_valid <= 1'b0;
`ifdef MAC_SCHED_WDOG_EN
      stall_cnt <= '0;
      err       <= 1'b0;
`endif
    end else begin
`ifdef MAC_SCHED_WDOG_EN
      err <= stall_hit;
`endif
      case (state)
        IDLE: begin
          if (in_valid0 || in_valid1) begin
            grant    <= (in_valid0 && in_valid1) ? rr_ptr : in_valid1;
            beat_cnt <= '0;
            state    <= RUN;
`ifdef MAC_SCHED_WDOG_EN
            stall_cnt <= '0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              mac_out   <= acc_nxt;
              out_src   <= grant;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
`ifdef MAC_SCHED_WDOG_EN
          else if (stall_hit) begin
            state <= ABORT;
          end
          stall_cnt <= accept ? '0 : stall_cnt + 1'b1;
`endif
        end
        DONE: begin
          // The finished requester yields priority to the other one.
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= ~grant;
            state     <= IDLE;
          end
        end
`ifdef MAC_SCHED_WDOG_EN
        ABORT: begin
          rr_ptr <= ~grant;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_sched.sv
// Directed self-checking bench for mac_sched; the watchdog scenario runs when MAC_SCHED_WDOG_EN is defined.
module tb_mac_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        in_ready0, in_ready1;
  logic [10:0] mac_out;
  logic        out_src, out_valid;
  logic        out_ready = 1'b0;
  logic        err;

  int errors = 0;
  int checks = 0;

  mac_sched dut (
    .clk(clk), .reset(reset),
    .in_a0(in_a0), .in_b0(in_b0), .in_valid0(in_valid0), .in_ready0(in_ready0),
    .in_a1(in_a1), .in_b1(in_b1), .in_valid1(in_valid1), .in_ready1(in_ready1),
    .mac_out(mac_out), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Holds the caller's inputs and counts accepts for src; stray counts cycles the other ready was high.
  task automatic feed(input bit src, input int n, output int got, output int stray);
    got = 0;
    stray = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      logic rdy, oth, vld;
      rdy = src ? in_ready1 : in_ready0;
      oth = src ? in_ready0 : in_ready1;
      vld = src ? in_valid1 : in_valid0;
      if (oth) stray++;
      @(posedge clk);
      if (rdy && vld) got++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (mac_out !== 11'd0) begin errors++; $display("FAIL reset_mac_out: got %h want 000", mac_out); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL reset_out_src: got %b want 0", out_src); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if ({in_ready0, in_ready1} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {in_ready0, in_ready1}); end
  endtask

  task automatic test_single();
    int got, stray;
    do_reset();
    out_ready = 1'b1;  // high while no result is pending: must do nothing
    in_a0 = 4'd1; in_b0 = 4'd1; in_valid0 = 1'b1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL single_idle_ready: got %b want 0", in_ready0); end
    feed(1'b0, 8, got, stray);
    in_valid0 = 1'b0;
    checks++; if (got !== 8) begin errors++; $display("FAIL single_accepts: got %0d want 8", got); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL single_stray_ready: got %0d want 0", stray); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid %b want 1", out_valid); end
    checks++; if (mac_out !== 11'd8) begin errors++; $display("FAIL single_sum: got %h want 008", mac_out); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL single_src: got %b want 0", out_src); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop: out_valid %b want 0", out_valid); end
    checks++; if (mac_out !== 11'd8) begin errors++; $display("FAIL single_hold_after: got %h want 008", mac_out); end
  endtask

  task automatic test_round_robin();
    int got, stray;
    do_reset();
    in_a0 = 4'd2; in_b0 = 4'd3; in_a1 = 4'hF; in_b1 = 4'd5;
    in_valid0 = 1'b1; in_valid1 = 1'b1;
    feed(1'b0, 8, got, stray);
    in_valid0 = 1'b0;
    checks++; if (got !== 8 || stray !== 0) begin errors++; $display("FAIL rr_first_burst: accepts %0d stray %0d want 8/0", got, stray); end
    checks++; if (out_valid !== 1'b1 || mac_out !== 11'd48 || out_src !== 1'b0) begin
      errors++; $display("FAIL rr_first_result: valid %b sum %h src %b want 1/030/0", out_valid, mac_out, out_src); end
    handshake();
    feed(1'b1, 8, got, stray);
    in_valid1 = 1'b0;
    checks++; if (got !== 8 || stray !== 0) begin errors++; $display("FAIL rr_second_burst: accepts %0d stray %0d want 8/0", got, stray); end
    checks++; if (out_valid !== 1'b1 || mac_out !== 11'h7D8 || out_src !== 1'b1) begin
      errors++; $display("FAIL rr_second_result: valid %b sum %h src %b want 1/7d8/1", out_valid, mac_out, out_src); end
    handshake();
  endtask

  task automatic test_extremes();
    int got, stray;
    do_reset();
    in_a0 = 4'h8; in_b0 = 4'h8; in_valid0 = 1'b1;
    feed(1'b0, 8, got, stray);
    in_valid0 = 1'b0;
    checks++; if (got !== 8 || mac_out !== 11'h200 || mac_out[10] !== 1'b0) begin
      errors++; $display("FAIL ext_max: accepts %0d sum %h want 8/200", got, mac_out); end
    handshake();
    in_a0 = 4'h8; in_b0 = 4'd7; in_valid0 = 1'b1;
    feed(1'b0, 8, got, stray);
    in_valid0 = 1'b0;
    checks++; if (got !== 8 || mac_out !== 11'h640) begin
      errors++; $display("FAIL ext_min: accepts %0d sum %h want 8/640", got, mac_out); end
    checks++; if (mac_out[10] !== 1'b1) begin errors++; $display("FAIL ext_min_sign: got %b want 1", mac_out[10]); end
    handshake();
  endtask

  task automatic test_gaps();
    int got, stray, total;
    do_reset();
    total = 0;
    in_a0 = 4'd3; in_b0 = 4'hE;
    for (int k = 0; k < 8; k++) begin
      in_valid0 = 1'b1;
      feed(1'b0, 1, got, stray);
      total += got;
      in_valid0 = 1'b0;
      repeat (2) @(negedge clk);
    end
    checks++; if (total !== 8 || out_valid !== 1'b1 || mac_out !== 11'h7D0) begin
      errors++; $display("FAIL gaps_sum: accepts %0d valid %b sum %h want 8/1/7d0", total, out_valid, mac_out); end
    handshake();
  endtask

  task automatic test_hold();
    int got, stray;
    do_reset();
    in_a1 = 4'd1; in_b1 = 4'd2; in_valid1 = 1'b1;
    feed(1'b1, 8, got, stray);
    in_valid0 = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL hold_accepts: got %0d want 8", got); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || mac_out !== 11'd16 || out_src !== 1'b1 || {in_ready0, in_ready1} !== 2'b00) begin
        errors++; $display("FAIL hold_cycle%0d: valid %b sum %h src %b rdy %b want 1/010/1/00",
                           c, out_valid, mac_out, out_src, {in_ready0, in_ready1});
      end
      @(posedge clk);
      @(negedge clk);
    end
    handshake();
    checks++; if (out_valid !== 1'b0 || {in_ready0, in_ready1} !== 2'b00 || mac_out !== 11'd16) begin
      errors++; $display("FAIL hold_release: valid %b rdy %b sum %h want 0/00/010", out_valid, {in_ready0, in_ready1}, mac_out); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({in_ready0, in_ready1} !== 2'b10) begin
      errors++; $display("FAIL hold_next_grant: rdy0/1 %b want 10", {in_ready0, in_ready1}); end
  endtask

  task automatic test_reset_mid();
    int got, stray;
    do_reset();
    in_a0 = 4'd1; in_b0 = 4'd1; in_valid0 = 1'b1;
    feed(1'b0, 3, got, stray);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || mac_out !== 11'd0 || out_src !== 1'b0 || err !== 1'b0 || {in_ready0, in_ready1} !== 2'b00) begin
      errors++; $display("FAIL midreset_outputs: valid %b sum %h src %b err %b rdy %b want all 0",
                         out_valid, mac_out, out_src, err, {in_ready0, in_ready1}); end
    feed(1'b0, 8, got, stray);
    in_valid0 = 1'b0;
    checks++; if (got !== 8 || out_valid !== 1'b1 || mac_out !== 11'd8) begin
      errors++; $display("FAIL midreset_next_burst: accepts %0d valid %b sum %h want 8/1/008", got, out_valid, mac_out); end
    handshake();
  endtask

`ifdef MAC_SCHED_WDOG_EN
  task automatic test_wdog();
    int got, stray, first_err, err_cnt, ov_cnt, first_r1;
    do_reset();
    in_a0 = 4'd1; in_b0 = 4'd1; in_a1 = 4'd1; in_b1 = 4'd1;
    in_valid0 = 1'b1; in_valid1 = 1'b1;
    feed(1'b0, 2, got, stray);
    in_valid0 = 1'b0;
    first_err = -1; err_cnt = 0; ov_cnt = 0; first_r1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (err) begin err_cnt++; if (first_err < 0) first_err = c; end
      if (out_valid) ov_cnt++;
      if (in_ready1 && first_r1 < 0) first_r1 = c;
    end
    in_valid1 = 1'b0;
    checks++; if (err_cnt !== 1 || first_err !== 15) begin
      errors++; $display("FAIL wdog_err_pulse: count %0d first %0d want 1/15", err_cnt, first_err); end
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL wdog_no_result: got %0d want 0", ov_cnt); end
    checks++; if (first_r1 !== 17) begin errors++; $display("FAIL wdog_regrant: cycle %0d want 17", first_r1); end
  endtask
`else
  task automatic test_no_wdog();
    int got, stray, err_cnt, ov_cnt, rdy_cnt;
    do_reset();
    in_a0 = 4'd1; in_b0 = 4'd1; in_valid0 = 1'b1;
    feed(1'b0, 2, got, stray);
    in_valid0 = 1'b0;
    err_cnt = 0; ov_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (in_ready0) rdy_cnt++;
    end
    checks++; if (err_cnt !== 0 || ov_cnt !== 0 || rdy_cnt !== 40) begin
      errors++; $display("FAIL nowdog_stall: err %0d valid %0d ready %0d want 0/0/40", err_cnt, ov_cnt, rdy_cnt); end
    in_valid0 = 1'b1;
    feed(1'b0, 6, got, stray);
    in_valid0 = 1'b0;
    checks++; if (got !== 6 || out_valid !== 1'b1 || mac_out !== 11'd8) begin
      errors++; $display("FAIL nowdog_resume: accepts %0d valid %b sum %h want 6/1/008", got, out_valid, mac_out); end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_gaps();
    test_hold();
    test_reset_mid();
`ifdef MAC_SCHED_WDOG_EN
    test_wdog();
`else
    test_no_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning operand pairs per burst (legal 1..8).
REQ-002 SHALL have parameter WDOG_CYC, default 15, meaning the stall limit in cycles, used only with MAC_SCHED_WDOG_EN.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_a0, in_b0  input  4 each  signed operands from requester 0.
REQ-006 SHALL have port in_valid0  input  1  requester 0 operand pair valid; also acts as its request.
REQ-007 SHALL have port in_ready0  output  1  requester 0 operand pair accepted this cycle.
REQ-008 SHALL have ports in_a1, in_b1, in_valid1, in_ready1 with the same widths and meaning for requester 1.
REQ-009 SHALL have port mac_out  output  11  signed burst sum.
REQ-010 SHALL have port out_src  output  1  requester index that owns mac_out.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port err  output  1  one-cycle abort pulse; tied 0 without MAC_SCHED_WDOG_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE, plus ABORT only with MAC_SCHED_WDOG_EN.
REQ-015 In IDLE, SHALL grant a requester whose in_valid is high; with both high, SHALL grant the round-robin pointer's choice; SHALL then go to RUN next cycle.
REQ-016 SHALL assert in_readyN combinationally only in RUN and only for the granted N; the other ready SHALL stay 0.
REQ-017 SHALL treat an operand pair as accepted on a posedge where in_validN and in_readyN are both 1.
REQ-018 On the first accept of a burst, SHALL load acc = a*b; on each later accept, SHALL set acc = acc + a*b, with signed 4x4 to 8-bit products sign-extended to 11 bits.
REQ-019 SHALL never overflow, since the range is -448..+512 for LEN<=8; no saturation is required.
REQ-020 SHALL ignore a cycle with in_valid low during RUN: no accept and no accumulate.
REQ-021 On the LEN-th accept, SHALL enter DONE; the next cycle SHALL show out_valid=1, mac_out=final acc and out_src=grant, giving 1-cycle latency.
REQ-022 In DONE, SHALL hold mac_out, out_src and out_valid stable until out_ready=1; SHALL deassert all in_ready; on the handshake SHALL return to IDLE and point the round-robin pointer at the other requester.
REQ-023 SHALL hold an out_ready that is high while out_valid=0 with no effect.
REQ-024 SHALL keep mac_out holding the last result after out_valid drops.

Reset
REQ-025 SHALL, on reset=1 at a posedge in any state, go to IDLE and set acc, mac_out, out_src, out_valid, err, the beat counter and the stall counter to 0, and the pointer to requester 0.
REQ-026 SHALL discard any partial burst on reset, with no out_valid for it.
REQ-027 SHALL have in_ready0 and in_ready1 at 0 in the cycle after reset.

Configuration
REQ-028 SHALL use macro MAC_SCHED_WDOG_EN.
REQ-029 With MAC_SCHED_WDOG_EN defined, SHALL count consecutive RUN cycles with no accept; when the count reaches WDOG_CYC, SHALL go to ABORT, pulse err for one cycle, discard acc, produce no out_valid, advance the pointer and return to IDLE.
REQ-030 Without MAC_SCHED_WDOG_EN, SHALL have no stall counter and no ABORT state, SHALL stay in RUN indefinitely and SHALL keep err constant 0.

Structure
REQ-031 SHALL place in shared package mac_sched_pkg: the FSM state enum, OP_W=4, ACC_W=11 and LEN_MAX=8.
REQ-032 SHALL implement the datapath as sub-module mac_sched_acc, containing the multiplier, the accumulator, and load/accumulate/clear controls; mac_sched SHALL contain only the FSM, arbitration and counters.

Verification
REQ-033 SHALL cover: only requester 0, a=1,b=1 for 8 pairs -> mac_out=8, out_src=0, out_valid 1 cycle after 8th accept.
REQ-034 SHALL cover: both requesters valid from reset, r0 a=2,b=3, r1 a=-1,b=5 -> r0 first (48, src 0), then r1 (-40, src 1).
REQ-035 SHALL cover: extremes a=-8,b=-8 x8 -> 512; a=-8,b=7 x8 -> -448; check the sign of the 11-bit result.
REQ-036 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, both in_ready 0, then one handshake and return to IDLE.
REQ-037 SHALL cover: reset asserted after 3 accepts -> all outputs 0 next cycle; the next burst of 8x(1*1) gives 8, not 11.
REQ-038 SHALL cover: with MAC_SCHED_WDOG_EN, granted requester drops valid for 15 cycles after 2 accepts -> err pulses once, no out_valid, other requester granted next.
